fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter SelectSize, default 1, the width of ADDR_Src.
REQ-002 SHALL have parameter CountWidth, default 16, the width of FetchCount.
REQ-003 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  begins fetching from IDLE.
REQ-006 SHALL have port Halt  input  1  stops sequencing after the current instruction is accepted.
REQ-007 SHALL have port Jump  input  1  requests a PC load from the datapath DIn before the next fetch.
REQ-008 SHALL have port IR_Ack  input  1  the consumer accepts the instruction held in IR.
REQ-009 SHALL have port ADDR_Src  output  SelectSize  address mux select; 0 selects PC.
REQ-010 SHALL have port PC_Ld  output  1  PC load, active low.
REQ-011 SHALL have port PC_Inc  output  1  PC increment, active low.
REQ-012 SHALL have port IR_Ld  output  1  IR load, active low.
REQ-013 SHALL have port MEM_RW  output  1  memory read/write; 1 = read, 0 = write.
REQ-014 SHALL have port MEM_En  output  1  memory enable, active low.
REQ-015 SHALL have port IR_Valid  output  1  IR holds a fresh, unaccepted instruction.
REQ-016 SHALL have port Busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port FetchCount  output  CountWidth  count of completed fetches.

Function
REQ-018 SHALL be a Moore FSM with states IDLE, FETCH0, FETCH1, HOLD and JUMP; all outputs except FetchCount SHALL be decoded from the state alone.
REQ-019 SHALL drive MEM_RW=1 and ADDR_Src=0 in every state; the sequencer never writes memory.
REQ-020 IDLE SHALL drive all active-low controls high (PC_Ld, PC_Inc, IR_Ld, MEM_En = 1), IR_Valid=0 and Busy=0.
REQ-021 FETCH0 SHALL drive MEM_En=0, with all other controls inactive.
REQ-022 FETCH1 SHALL drive MEM_En=0, IR_Ld=0 and PC_Inc=0, so IR captures the word while PC advances.
REQ-023 HOLD SHALL drive IR_Valid=1, with all active-low controls inactive.
REQ-024 JUMP SHALL drive PC_Ld=0 for exactly one cycle, with PC_Inc, IR_Ld and MEM_En inactive.
REQ-025 IDLE transitions: Jump=1 -> JUMP; else Start=1 -> FETCH0; else stay. Jump takes priority over Start.
REQ-026 FETCH0 -> FETCH1 unconditionally.
REQ-027 FETCH1 -> HOLD unconditionally.
REQ-028 JUMP -> FETCH0 unconditionally.
REQ-029 In HOLD with IR_Ack=0, the FSM SHALL stay in HOLD and ignore Halt and Jump.
REQ-030 In HOLD with IR_Ack=1, priority SHALL be: Halt -> IDLE; else Jump -> JUMP; else -> FETCH0.
REQ-031 Start, Halt, Jump and IR_Ack SHALL be ignored in FETCH0, FETCH1 and JUMP, and SHALL not be remembered.
REQ-032 Latency: Start sampled in IDLE at edge n SHALL give IR_Valid=1 after edge n+3.
REQ-033 Latency: IR_Ack sampled in HOLD (no Halt, no Jump) at edge n SHALL give IR_Valid=1 again after edge n+3; with Jump, after edge n+4.
REQ-034 FetchCount SHALL increment by 1 on each FETCH1 -> HOLD transition and SHALL wrap from all-ones to 0 without a flag.
REQ-035 PC_Ld=0 and PC_Inc=0 SHALL never be asserted in the same cycle.

Reset
REQ-036 Reset=1 at a rising edge SHALL force IDLE and FetchCount=0 in any state, including mid-fetch, overriding all other inputs.
REQ-037 After reset, outputs SHALL be: PC_Ld=PC_Inc=IR_Ld=MEM_En=1, MEM_RW=1, ADDR_Src=0, IR_Valid=0, Busy=0.
REQ-038 While Reset=1 is held, the FSM SHALL remain in IDLE.

Verification
REQ-039 Basic fetch: reset, then pulse Start for 1 cycle -> MEM_En low for 2 cycles, IR_Ld and PC_Inc low in the 2nd cycle, then IR_Valid=1 and FetchCount=1.
REQ-040 Back-to-back fetches: hold IR_Ack=1 continuously -> repeating 3-cycle pattern FETCH0/FETCH1/HOLD; FetchCount = 5 after 5 HOLD entries.
REQ-041 Jump: in HOLD assert IR_Ack=1 and Jump=1 -> one cycle of PC_Ld=0, then FETCH0; PC_Inc never low in the same cycle as PC_Ld.
REQ-042 Halt priority: in HOLD assert IR_Ack=1, Halt=1 and Jump=1 -> IDLE next cycle, Busy=0, no PC_Ld pulse.
REQ-043 Reset mid-operation: assert Reset in FETCH1 -> IDLE next cycle, FetchCount=0, all controls inactive; a later Start resumes the normal sequence.
REQ-044 Wrap: with CountWidth=2, complete 4 fetches -> FetchCount reads 1, 2, 3, 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: Moore FSM driving PC/IR/memory controls
// for a fetch-hold-accept loop, with jump and halt handling.
module fetch_sequencer #(
   parameter int unsigned SelectSize = 1,
   parameter int unsigned CountWidth = 16
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic                  Halt,
   input  logic                  Jump,
   input  logic                  IR_Ack,
   output logic [SelectSize-1:0] ADDR_Src,
   output logic                  PC_Ld,
   output logic                  PC_Inc,
   output logic                  IR_Ld,
   output logic                  MEM_RW,
   output logic                  MEM_En,
   output logic                  IR_Valid,
   output logic                  Busy,
   output logic [CountWidth-1:0] FetchCount
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH0 = 3'd1,
      FETCH1 = 3'd2,
      HOLD   = 3'd3,
      JUMP   = 3'd4
   } state_t;

   state_t state;

   // Next-state decode; inputs outside IDLE and HOLD are deliberately dropped.
   function automatic state_t next_of(state_t s, logic start, logic halt,
                                      logic jump, logic ack);
      state_t n;
      n = IDLE;
      case (s)
         IDLE: begin
            if (jump)       n = JUMP;
            else if (start) n = FETCH0;
            else            n = IDLE;
         end
         FETCH0: n = FETCH1;
         FETCH1: n = HOLD;
         JUMP:   n = FETCH0;
         HOLD: begin
            if (!ack)      n = HOLD;
            else if (halt) n = IDLE;
            else if (jump) n = JUMP;
            else           n = FETCH0;
         end
         default: n = IDLE;
      endcase
      return n;
   endfunction

   // State register, fetch counter and registered control decode of the current state.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         FetchCount <= '0;
         ADDR_Src   <= '0;
         MEM_RW     <= 1'b1;
         PC_Ld      <= 1'b1;
         PC_Inc     <= 1'b1;
         IR_Ld      <= 1'b1;
         MEM_En     <= 1'b1;
         IR_Valid   <= 1'b0;
         Busy       <= 1'b0;
      end else begin
         state <= next_of(state, Start, Halt, Jump, IR_Ack);

         // One completed fetch per FETCH1 -> HOLD transition; wraps silently.
         if (state == FETCH1)
            FetchCount <= FetchCount + CountWidth'(1);

         ADDR_Src <= '0;
         MEM_RW   <= 1'b1;
         PC_Ld    <= 1'b1;
         PC_Inc   <= 1'b1;
         IR_Ld    <= 1'b1;
         MEM_En   <= 1'b1;
         IR_Valid <= 1'b0;
         Busy     <= 1'b1;
         case (state)
            IDLE:   Busy <= 1'b0;
            FETCH0: MEM_En <= 1'b0;
            FETCH1: begin
               MEM_En <= 1'b0;
               IR_Ld  <= 1'b0;
               PC_Inc <= 1'b0;
            end
            HOLD:   IR_Valid <= 1'b1;
            JUMP:   PC_Ld <= 1'b0;
            default: Busy <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: control patterns, latency, jump/halt,
// reset and counter wrap (second instance with a 2-bit counter).
module tb_fetch_sequencer;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Start = 1'b0;
   logic       Halt = 1'b0;
   logic       Jump = 1'b0;
   logic       IR_Ack = 1'b0;

   logic [0:0]  ADDR_Src, w_ADDR_Src;
   logic        PC_Ld, PC_Inc, IR_Ld, MEM_RW, MEM_En, IR_Valid, Busy;
   logic        w_PC_Ld, w_PC_Inc, w_IR_Ld, w_MEM_RW, w_MEM_En, w_IR_Valid, w_Busy;
   logic [15:0] FetchCount;
   logic [1:0]  w_FetchCount;

   int n_checks = 0;
   int n_fail   = 0;

   // Output bundle: {PC_Ld, PC_Inc, IR_Ld, MEM_En, MEM_RW, ADDR_Src, IR_Valid, Busy}
   logic [7:0] obs;
   assign obs = {PC_Ld, PC_Inc, IR_Ld, MEM_En, MEM_RW, ADDR_Src, IR_Valid, Busy};

   localparam logic [7:0] P_IDLE = 8'b1111_1000;
   localparam logic [7:0] P_F0   = 8'b1110_1001;
   localparam logic [7:0] P_F1   = 8'b1000_1001;
   localparam logic [7:0] P_HOLD = 8'b1111_1011;
   localparam logic [7:0] P_JUMP = 8'b0111_1001;

   always #5 Clk = ~Clk;

   fetch_sequencer u_dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Jump(Jump), .IR_Ack(IR_Ack),
      .ADDR_Src(ADDR_Src), .PC_Ld(PC_Ld), .PC_Inc(PC_Inc), .IR_Ld(IR_Ld), .MEM_RW(MEM_RW),
      .MEM_En(MEM_En), .IR_Valid(IR_Valid), .Busy(Busy), .FetchCount(FetchCount)
   );

   fetch_sequencer #(.SelectSize(1), .CountWidth(2)) u_wrap (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Jump(Jump), .IR_Ack(IR_Ack),
      .ADDR_Src(w_ADDR_Src), .PC_Ld(w_PC_Ld), .PC_Inc(w_PC_Inc), .IR_Ld(w_IR_Ld),
      .MEM_RW(w_MEM_RW), .MEM_En(w_MEM_En), .IR_Valid(w_IR_Valid), .Busy(w_Busy),
      .FetchCount(w_FetchCount)
   );

   // One rising edge, then settle to the falling edge for sampling and driving.
   task automatic step();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic do_reset();
      Reset = 1'b1; Start = 1'b0; Halt = 1'b0; Jump = 1'b0; IR_Ack = 1'b0;
      step();
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Start = 1'b1; Halt = 1'b1; Jump = 1'b1; IR_Ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (obs !== P_IDLE) begin
            n_fail++; $display("FAIL reset_outputs[%0d]: got %b want %b", i, obs, P_IDLE);
         end
         n_checks++;
         if (FetchCount !== 16'd0) begin
            n_fail++; $display("FAIL reset_count[%0d]: got %0d want 0", i, FetchCount);
         end
      end
      Reset = 1'b0; Start = 1'b0; Halt = 1'b0; Jump = 1'b0; IR_Ack = 1'b0;
      step();
      n_checks++;
      if (obs !== P_IDLE) begin
         n_fail++; $display("FAIL idle_stays: got %b want %b", obs, P_IDLE);
      end
   endtask

   task automatic test_basic_fetch();
      logic [7:0] exp_seq [4];
      exp_seq = '{P_IDLE, P_F0, P_F1, P_HOLD};
      do_reset();
      Start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         Start = 1'b0;
         n_checks++;
         if (obs !== exp_seq[i]) begin
            n_fail++; $display("FAIL basic_seq[%0d]: got %b want %b", i, obs, exp_seq[i]);
         end
      end
      n_checks++;
      if (FetchCount !== 16'd1) begin
         n_fail++; $display("FAIL basic_count: got %0d want 1", FetchCount);
      end
      // Halt/Jump without IR_Ack are ignored in HOLD.
      Halt = 1'b1; Jump = 1'b1;
      step(); step();
      n_checks++;
      if (obs !== P_HOLD) begin
         n_fail++; $display("FAIL hold_no_ack: got %b want %b", obs, P_HOLD);
      end
      Halt = 1'b0; Jump = 1'b0;
   endtask

   task automatic test_ignore_in_fetch();
      do_reset();
      Start = 1'b1;
      step();
      Start = 1'b0;
      // Pulse everything while the state is FETCH0 / FETCH1.
      Halt = 1'b1; Jump = 1'b1; IR_Ack = 1'b1; Start = 1'b1;
      step(); step();
      Halt = 1'b0; Jump = 1'b0; IR_Ack = 1'b0; Start = 1'b0;
      step();
      n_checks++;
      if (obs !== P_HOLD) begin
         n_fail++; $display("FAIL ignore_reach_hold: got %b want %b", obs, P_HOLD);
      end
      step();
      n_checks++;
      if (obs !== P_HOLD) begin
         n_fail++; $display("FAIL ignore_not_remembered: got %b want %b", obs, P_HOLD);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] pat [3];
      pat = '{P_F0, P_F1, P_HOLD};
      do_reset();
      IR_Ack = 1'b1; Start = 1'b1;
      step();
      Start = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         n_checks++;
         if (obs !== pat[i % 3]) begin
            n_fail++; $display("FAIL b2b_seq[%0d]: got %b want %b", i, obs, pat[i % 3]);
         end
         if (i % 3 == 2) begin
            n_checks++;
            if (FetchCount !== 16'(i / 3 + 1)) begin
               n_fail++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, FetchCount, i / 3 + 1);
            end
         end
      end
      IR_Ack = 1'b0;
   endtask

   task automatic test_jump();
      logic [7:0] exp_seq [5];
      exp_seq = '{P_HOLD, P_JUMP, P_F0, P_F1, P_HOLD};
      do_reset();
      Start = 1'b1;
      step();
      Start = 1'b0;
      step(); step(); step();
      IR_Ack = 1'b1; Jump = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         IR_Ack = 1'b0; Jump = 1'b0;
         n_checks++;
         if (obs !== exp_seq[i]) begin
            n_fail++; $display("FAIL jump_seq[%0d]: got %b want %b", i, obs, exp_seq[i]);
         end
         n_checks++;
         if (PC_Ld === 1'b0 && PC_Inc === 1'b0) begin
            n_fail++; $display("FAIL jump_ld_inc_overlap[%0d]: got PC_Ld=0 PC_Inc=0 want not both low", i);
         end
      end
      n_checks++;
      if (FetchCount !== 16'd2) begin
         n_fail++; $display("FAIL jump_count: got %0d want 2", FetchCount);
      end
      // Jump from IDLE wins over Start.
      do_reset();
      Jump = 1'b1; Start = 1'b1;
      step();
      Jump = 1'b0; Start = 1'b0;
      step();
      n_checks++;
      if (obs !== P_JUMP) begin
         n_fail++; $display("FAIL idle_jump_priority: got %b want %b", obs, P_JUMP);
      end
      step();
      n_checks++;
      if (obs !== P_F0) begin
         n_fail++; $display("FAIL idle_jump_then_f0: got %b want %b", obs, P_F0);
      end
   endtask

   task automatic test_halt_priority();
      do_reset();
      Start = 1'b1;
      step();
      Start = 1'b0;
      step(); step(); step();
      IR_Ack = 1'b1; Halt = 1'b1; Jump = 1'b1;
      step();
      IR_Ack = 1'b0; Halt = 1'b0; Jump = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (obs !== P_IDLE) begin
            n_fail++; $display("FAIL halt_idle[%0d]: got %b want %b", i, obs, P_IDLE);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp_seq [4];
      exp_seq = '{P_IDLE, P_F0, P_F1, P_HOLD};
      do_reset();
      Start = 1'b1;
      step();
      Start = 1'b0;
      step();
      // State is FETCH1 now; reset on the next edge.
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      n_checks++;
      if (obs !== P_IDLE) begin
         n_fail++; $display("FAIL mid_reset_outputs: got %b want %b", obs, P_IDLE);
      end
      n_checks++;
      if (FetchCount !== 16'd0) begin
         n_fail++; $display("FAIL mid_reset_count: got %0d want 0", FetchCount);
      end
      step();
      n_checks++;
      if (obs !== P_IDLE) begin
         n_fail++; $display("FAIL mid_reset_stays_idle: got %b want %b", obs, P_IDLE);
      end
      Start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         Start = 1'b0;
         n_checks++;
         if (obs !== exp_seq[i]) begin
            n_fail++; $display("FAIL resume_seq[%0d]: got %b want %b", i, obs, exp_seq[i]);
         end
      end
      n_checks++;
      if (FetchCount !== 16'd1) begin
         n_fail++; $display("FAIL resume_count: got %0d want 1", FetchCount);
      end
   endtask

   task automatic test_wrap();
      logic [1:0] exp_cnt [4];
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      IR_Ack = 1'b1; Start = 1'b1;
      step();
      Start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step(); step(); step();
         n_checks++;
         if (w_IR_Valid !== 1'b1 || w_FetchCount !== exp_cnt[k]) begin
            n_fail++;
            $display("FAIL wrap_count[%0d]: got valid=%b count=%0d want valid=1 count=%0d",
                     k, w_IR_Valid, w_FetchCount, exp_cnt[k]);
         end
      end
      IR_Ack = 1'b0;
   endtask

   initial begin
      @(negedge Clk);
      test_reset();
      test_basic_fetch();
      test_ignore_in_fetch();
      test_back_to_back();
      test_jump();
      test_halt_priority();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
